frame_fetch_ctrl: RTL

//  Sequences MP3 frame playback from the BRAM frame feeder into the parser chain.

---
 rtl/frame_fetch_if.sv | 22 ++
 rtl/frame_fetch_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/frame_fetch_if.sv
// rtl/frame_fetch_if.sv - feeder/header-parser handshake bundle for frame_fetch_ctrl
interface frame_fetch_if #(
    parameter int FRAME_NUM_W = 7,
    parameter int SIZE_W      = 11
);
    logic                   frame_num_ov;
    logic [FRAME_NUM_W-1:0] frame_num_od;
    logic                   byte_iv;
    logic                   header_iv;
    logic [SIZE_W-1:0]      frame_size_id;
    logic                   fifo_afull_i;

    modport master (
        output frame_num_ov, frame_num_od,
        input  byte_iv, header_iv, frame_size_id, fifo_afull_i
    );

    modport slave (
        input  frame_num_ov, frame_num_od,
        output byte_iv, header_iv, frame_size_id, fifo_afull_i
    );
endinterface

// File: rtl/frame_fetch_ctrl.sv
// rtl/frame_fetch_ctrl.sv - per-frame request sequencer with byte counting, back-pressure hold and header timeout
module frame_fetch_ctrl #(
    parameter int FRAME_NUM_W = 7,
    parameter int SIZE_W      = 11,
    parameter int HDR_TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [FRAME_NUM_W-1:0] first_frame_i,
    input  logic [FRAME_NUM_W-1:0] num_frames_i,
    frame_fetch_if.master          ff,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [FRAME_NUM_W-1:0] frame_cnt_o
);
    localparam int TW = $clog2(HDR_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, REQUEST, WAIT_HDR, STREAM, HOLD, DONE, ERROR
    } state_t;

    state_t                 state_q, state_d;
    logic [FRAME_NUM_W-1:0] cur_q, cur_d;
    logic [FRAME_NUM_W:0]   rem_q, rem_d;
    logic [FRAME_NUM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [SIZE_W-1:0]      bcnt_q, bcnt_d, bcnt_inc;
    logic [SIZE_W-1:0]      fsize_q, fsize_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   error_q, error_d;
    logic                   complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            rem_q       <= '0;
            frame_cnt_q <= '0;
            bcnt_q      <= '0;
            fsize_q     <= '0;
            timer_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            frame_cnt_q <= frame_cnt_d;
            bcnt_q      <= bcnt_d;
            fsize_q     <= fsize_d;
            timer_q     <= timer_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        rem_d       = rem_q;
        frame_cnt_d = frame_cnt_q;
        bcnt_d      = bcnt_q;
        fsize_d     = fsize_q;
        timer_d     = timer_q;
        error_d     = error_q;
        complete    = 1'b0;
        // Byte counter saturates so an oversized burst cannot wrap back onto fsize.
        bcnt_inc    = (bcnt_q == '1) ? bcnt_q : bcnt_q + 1'b1;

        if (abort_i && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cur_d       = first_frame_i;
                        rem_d       = {1'b0, num_frames_i};
                        if (num_frames_i == '0)
                            rem_d = {1'b1, {FRAME_NUM_W{1'b0}}};
                        error_d     = 1'b0;
                        frame_cnt_d = '0;
                        state_d     = REQUEST;
                    end
                end
                REQUEST: begin
                    bcnt_d  = '0;
                    timer_d = '0;
                    state_d = WAIT_HDR;
                end
                WAIT_HDR: begin
                    if (ff.byte_iv)
                        bcnt_d = bcnt_inc;
                    timer_d = timer_q + 1'b1;
                    // Header is checked before the timeout so a late header still wins.
                    if (ff.header_iv) begin
                        fsize_d = ff.frame_size_id;
                        if (ff.frame_size_id < SIZE_W'(4)) begin
                            error_d = 1'b1;
                            state_d = ERROR;
                        end else if (ff.frame_size_id <= bcnt_d) begin
                            complete = 1'b1;
                        end else begin
                            state_d = STREAM;
                        end
                    end else if (timer_q == TW'(HDR_TIMEOUT - 1)) begin
                        error_d = 1'b1;
                        state_d = ERROR;
                    end
                end
                STREAM: begin
                    if (ff.byte_iv) begin
                        bcnt_d = bcnt_inc;
                        if (bcnt_inc == fsize_q)
                            complete = 1'b1;
                    end
                end
                HOLD: begin
                    if (!ff.fifo_afull_i)
                        state_d = REQUEST;
                end
                DONE:    state_d = IDLE;
                ERROR:   state_d = IDLE;
                default: state_d = IDLE;
            endcase

            if (complete) begin
                cur_d       = cur_q + 1'b1;
                frame_cnt_d = frame_cnt_q + 1'b1;
                rem_d       = rem_q - 1'b1;
                if (rem_q == (FRAME_NUM_W + 1)'(1))
                    state_d = DONE;
                else if (ff.fifo_afull_i)
                    state_d = HOLD;
                else
                    state_d = REQUEST;
            end
        end
    end

    assign ff.frame_num_ov = (state_q == REQUEST);
    assign ff.frame_num_od = (state_q == REQUEST) ? cur_q : '0;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign error_o         = error_q;
    assign frame_cnt_o     = frame_cnt_q;
endmodule
